// File: rtl/display_pkg.sv
// Shared display definitions for the binary-to-BCD converter and the
// per-digit 7-segment decoders downstream of it.
//   state_t   : converter FSM states
//   BCD_BLANK : digit code that the 7-segment decoder renders as all-off
//   bcd_max() : largest value representable in a given number of digits
package display_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < digits; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle between a requester and bin2bcd_seq.
//   start, bin              : requester -> converter
//   busy, done, bcd, overflow : converter -> requester / display
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, output bin,
                  input  busy, input done, input bcd, input overflow);
  modport slave  (input  start, input bin,
                  output busy, output done, output bcd, output overflow);
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next digit.
//   din  : 4-bit digit before correction
//   dout : corrected digit
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. The result is held stable on bcd/overflow until the next
// conversion finishes, so the downstream display never flickers.
//   clk, rst_n : clock and synchronous active-low reset
//   bus.start  : accept bus.bin when idle
//   bus.busy   : conversion in progress
//   bus.done   : one-cycle pulse, bcd/overflow just updated
//   bus.bcd    : BCD digits, digit 0 in [3:0]; all blank on overflow
//   bus.overflow : last accepted value exceeded 10^DIGITS-1
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int LZB    = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  bin2bcd_seq_if.slave   bus
);

  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int          SCR_W   = 4 * DIGITS;
  localparam logic [63:0] MAX_VAL = bcd_max(DIGITS);

  // Blank leading zero digits from the top; digit 0 is always shown.
  function automatic logic [SCR_W-1:0] lz_blank(input logic [SCR_W-1:0] v);
    logic [SCR_W-1:0] r;
    logic             seen;
    r    = v;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!seen && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = BCD_BLANK;
      end else begin
        seen = 1'b1;
      end
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic [SCR_W-1:0]       adj;
  logic [SCR_W+BIN_W-1:0] cat;
  logic [SCR_W-1:0]       scr_sh;
  logic [BIN_W-1:0]       shf_sh;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // One double-dabble iteration; anything shifted out of the top digit is
  // dropped (only possible on overflow, where the result is blanked anyway).
  always_comb begin
    cat             = {adj, shift_q};
    {scr_sh, shf_sh} = cat << 1;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d    = bus.bin;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = (64'(bus.bin) > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shf_sh;
        scratch_d = scr_sh;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          overflow_d = ovf_pend_q;
          if (ovf_pend_q) begin
            bcd_d = {DIGITS{BCD_BLANK}};
          end else if (LZB != 0) begin
            bcd_d = lz_blank(scr_sh);
          end else begin
            bcd_d = scr_sh;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= {DIGITS{BCD_BLANK}};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;

endmodule
